// File: rtl/shift_pkg.sv
// Shared definitions for the 64-bit shift execution unit: op encodings,
// datapath widths and the bit-reverse helper used to build right shifts.
package shift_pkg;

    localparam int XLEN    = 64;
    localparam int SHAMT_W = 6;

    typedef enum logic [1:0] {
        SHIFT_OP_SLL  = 2'b00,
        SHIFT_OP_SRL  = 2'b01,
        SHIFT_OP_SRA  = 2'b10,
        SHIFT_OP_RSVD = 2'b11
    } shift_op_e;

    function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ShiftLogic_64.sv
// Left-only 64-bit shifter driven by a one-hot shift vector: output is
// datain shifted left by the index of the set bit (zero if no bit is set).
module ShiftLogic_64
    import shift_pkg::*;
(
    input  logic [XLEN-1:0] datain,
    input  logic [XLEN-1:0] shift,
    output logic [XLEN-1:0] dataout
);

    always_comb begin
        dataout = '0;
        for (int k = 0; k < XLEN; k++) begin
            if (shift[k]) begin
                dataout = dataout | (datain << k);
            end
        end
    end

endmodule

// File: rtl/shift_unit_64.sv
// Two-stage pipelined SLL/SRL/SRA unit with valid/ready on both sides.
// Define SHIFT_W_OPS_EN to add the RV64 word variants (SLLW/SRLW/SRAW).
module shift_unit_64
    import shift_pkg::*;
#(
    parameter int TAG_W = 5
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic               in_word,
    input  logic [XLEN-1:0]    in_a,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_data,
    output logic [TAG_W-1:0]   out_tag
);

    localparam logic [XLEN-1:0] ONE_HOT_BASE = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ALL_ONES     = {XLEN{1'b1}};

    logic s2_adv;
    logic s1_adv;
    logic s1_load;
    logic s2_load;

    logic               s1_valid_q,  s1_valid_d;
    shift_op_e          s1_op_q,     s1_op_d;
    logic [XLEN-1:0]    s1_a_q,      s1_a_d;
    logic [XLEN-1:0]    s1_onehot_q, s1_onehot_d;
    logic [TAG_W-1:0]   s1_tag_q,    s1_tag_d;
    logic [SHAMT_W-1:0] shamt_eff;

`ifdef SHIFT_W_OPS_EN
    logic s1_word_q, s1_word_d;
`else
    logic in_word_unused;
    assign in_word_unused = in_word;
`endif

    logic               s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]    s2_data_q,  s2_data_d;
    logic [TAG_W-1:0]   s2_tag_q,   s2_tag_d;

    logic [XLEN-1:0] prep;
    logic            is_right;
    logic [XLEN-1:0] shl_in;
    logic [XLEN-1:0] shl_out;
    logic [XLEN-1:0] ones_shl;
    logic [XLEN-1:0] sra_fill;
    logic [XLEN-1:0] result;

    // A stage may take new contents whenever it is empty or its current
    // contents are leaving this cycle, so a full pipe drains and refills
    // in the same clock without a bubble.
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        s1_load  = in_valid && s1_adv;
        s2_load  = s1_valid_q && s2_adv;
        in_ready = s1_adv;
    end

    always_comb begin
        shamt_eff = in_shamt;
`ifdef SHIFT_W_OPS_EN
        if (in_word) begin
            shamt_eff = {1'b0, in_shamt[4:0]};
        end
`endif
    end

    always_comb begin
        s1_valid_d  = s1_adv ? in_valid : s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_a_d      = s1_a_q;
        s1_onehot_d = s1_onehot_q;
        s1_tag_d    = s1_tag_q;
`ifdef SHIFT_W_OPS_EN
        s1_word_d   = s1_word_q;
`endif
        if (s1_load) begin
            s1_op_d     = shift_op_e'(in_op);
            s1_a_d      = in_a;
            s1_onehot_d = ONE_HOT_BASE << shamt_eff;
            s1_tag_d    = in_tag;
`ifdef SHIFT_W_OPS_EN
            s1_word_d   = in_word;
`endif
        end
    end

    // ---- S1 -> S2: operand prep and shift ----
    always_comb begin
        prep = s1_a_q;
`ifdef SHIFT_W_OPS_EN
        if (s1_word_q) begin
            if (s1_op_q == SHIFT_OP_SRA) begin
                prep = {{(XLEN-32){s1_a_q[31]}}, s1_a_q[31:0]};
            end else begin
                prep = {{(XLEN-32){1'b0}}, s1_a_q[31:0]};
            end
        end
`endif
        is_right = (s1_op_q == SHIFT_OP_SRL) || (s1_op_q == SHIFT_OP_SRA);
        shl_in   = is_right ? bit_rev(prep) : prep;
    end

    ShiftLogic_64 u_data_shift (
        .datain  (shl_in),
        .shift   (s1_onehot_q),
        .dataout (shl_out)
    );

    // Shifting all-ones gives the positions vacated by the shift; reversed
    // and inverted it marks the top k bits that SRA must fill with sign.
    ShiftLogic_64 u_mask_shift (
        .datain  (ALL_ONES),
        .shift   (s1_onehot_q),
        .dataout (ones_shl)
    );

    always_comb begin
        sra_fill = ~bit_rev(ones_shl) & {XLEN{prep[XLEN-1]}};
        result   = is_right ? bit_rev(shl_out) : shl_out;
        if (s1_op_q == SHIFT_OP_SRA) begin
            result = result | sra_fill;
        end
`ifdef SHIFT_W_OPS_EN
        if (s1_word_q) begin
            result = {{(XLEN-32){result[31]}}, result[31:0]};
        end
`endif
        if (s1_op_q == SHIFT_OP_RSVD) begin
            result = '0;
        end
    end

    always_comb begin
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_tag_d   = s2_tag_q;
        if (s2_load) begin
            s2_data_d = result;
            s2_tag_d  = s1_tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= SHIFT_OP_SLL;
            s1_a_q      <= '0;
            s1_onehot_q <= '0;
            s1_tag_q    <= '0;
`ifdef SHIFT_W_OPS_EN
            s1_word_q   <= 1'b0;
`endif
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_tag_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_onehot_q <= s1_onehot_d;
            s1_tag_q    <= s1_tag_d;
`ifdef SHIFT_W_OPS_EN
            s1_word_q   <= s1_word_d;
`endif
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_tag_q    <= s2_tag_d;
        end
    end

    // ---- S2 -> output ----
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_shift_unit_64.sv
// Self-checking bench for shift_unit_64: directed vectors, streaming,
// backpressure, randomized traffic and reset mid-flight.
module tb_shift_unit_64;

    localparam int TAG_W = 5;
`ifdef SHIFT_W_OPS_EN
    localparam bit WORD_EN = 1'b1;
`else
    localparam bit WORD_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic             in_word;
    logic [63:0]      in_a;
    logic [5:0]       in_shamt;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    shift_unit_64 #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_word   (in_word),
        .in_a      (in_a),
        .in_shamt  (in_shamt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       op;
        logic             word;
        logic [63:0]      a;
        logic [5:0]       sh;
        logic [TAG_W-1:0] tag;
    } op_t;

    op_t              pend[$];
    logic [63:0]      exp_d[$];
    logic [TAG_W-1:0] exp_t[$];
    int               acc_cyc[$];
    logic [63:0]      got_d[$];
    logic [TAG_W-1:0] got_t[$];
    int               got_cyc[$];
    int               cyc;
    int               n_vec;
    int               n_err;

    // Reference: shift semantics straight from the op definitions.
    function automatic logic [63:0] ref_shift(input logic [1:0] op, input logic word,
                                              input logic [63:0] a, input logic [5:0] sh);
        logic [63:0] r;
        logic [31:0] w;
        case (op)
            2'd0:    r = a << sh;
            2'd1:    r = a >> sh;
            2'd2:    r = $signed(a) >>> sh;
            default: r = '0;
        endcase
        if (word && op != 2'd3) begin
            case (op)
                2'd0:    w = a[31:0] << sh[4:0];
                2'd1:    w = a[31:0] >> sh[4:0];
                default: w = $signed(a[31:0]) >>> sh[4:0];
            endcase
            r = {{32{w[31]}}, w};
        end
        return r;
    endfunction

    function automatic op_t mk(input logic [1:0] op, input logic word, input logic [63:0] a,
                               input logic [5:0] sh, input logic [TAG_W-1:0] tag);
        op_t o;
        o.op = op; o.word = word; o.a = a; o.sh = sh; o.tag = tag;
        return o;
    endfunction

    task automatic clear_q();
        pend.delete(); exp_d.delete(); exp_t.delete(); acc_cyc.delete();
        got_d.delete(); got_t.delete(); got_cyc.delete();
    endtask

    // One clock: present the head of pend, observe handshakes at negedge.
    task automatic cycle(input bit rnd);
        bit               offer;
        bit               acc;
        bit               fire;
        logic [63:0]      d;
        logic [TAG_W-1:0] t;
        offer = 1'b1;
        if (rnd) begin
            out_ready = ($urandom_range(0, 3) != 0);
            offer     = ($urandom_range(0, 4) != 0);
        end
        if (offer && pend.size() > 0) begin
            in_valid = 1'b1;
            in_op    = pend[0].op;
            in_word  = pend[0].word;
            in_a     = pend[0].a;
            in_shamt = pend[0].sh;
            in_tag   = pend[0].tag;
        end else begin
            in_valid = 1'b0;
            in_a     = {$urandom, $urandom};
        end
        @(negedge clk);
        acc  = in_valid && in_ready;
        fire = out_valid && out_ready;
        d    = out_data;
        t    = out_tag;
        @(posedge clk);
        #1;
        if (acc) begin
            exp_d.push_back(ref_shift(pend[0].op, pend[0].word & WORD_EN, pend[0].a, pend[0].sh));
            exp_t.push_back(pend[0].tag);
            acc_cyc.push_back(cyc);
            void'(pend.pop_front());
        end
        if (fire) begin
            got_d.push_back(d);
            got_t.push_back(t);
            got_cyc.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic drain(input int budget);
        out_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (pend.size() == 0 && got_d.size() >= exp_d.size()) break;
            cycle(1'b0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_word = 1'b0;
        in_a = '0; in_shamt = '0; in_tag = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_vec++; if (out_data !== 64'd0) begin n_err++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        n_vec++; if (out_tag !== '0) begin n_err++; $display("FAIL reset_out_tag got %h exp 0", out_tag); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        rst_n = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [63:0] k[5];
        k[0] = 64'hAFA0F0FFAFA0F0F0; k[1] = 64'h0000000000000001;
        k[2] = 64'hFFFFFFFFFFFFFFFF; k[3] = 64'h0700000000000000; k[4] = 64'h0;
        clear_q();
        out_ready = 1'b1;
        pend.push_back(mk(2'd0, 1'b0, 64'hFAFA0F0FFAFA0F0F, 6'd4, 5'd1));
        pend.push_back(mk(2'd1, 1'b0, 64'h8000000000000000, 6'd63, 5'd2));
        pend.push_back(mk(2'd2, 1'b0, 64'h8000000000000000, 6'd63, 5'd3));
        pend.push_back(mk(2'd2, 1'b0, 64'h7000000000000000, 6'd4, 5'd4));
        pend.push_back(mk(2'd3, 1'b0, 64'h123456789ABCDEF0, 6'd7, 5'd5));
        drain(30);
        n_vec++; if (got_d.size() !== 5) begin n_err++; $display("FAIL directed_count got %0d exp 5", got_d.size()); end
        else begin
            n_vec++; if (got_cyc[0] !== acc_cyc[0] + 2) begin n_err++; $display("FAIL latency got %0d exp %0d", got_cyc[0] - acc_cyc[0], 2); end
            for (int i = 0; i < 5; i++) begin
                n_vec++; if (got_d[i] !== k[i]) begin n_err++; $display("FAIL directed_data[%0d] got %h exp %h", i, got_d[i], k[i]); end
                n_vec++; if (got_t[i] !== TAG_W'(i + 1)) begin n_err++; $display("FAIL directed_tag[%0d] got %0d exp %0d", i, got_t[i], i + 1); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a;
        a = {$urandom, $urandom};
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) pend.push_back(mk(2'd0, 1'b0, a, 6'(i), TAG_W'(i)));
        drain(100);
        n_vec++; if (got_d.size() !== 64) begin n_err++; $display("FAIL b2b_count got %0d exp 64", got_d.size()); end
        else begin
            for (int i = 0; i < 64; i++) begin
                n_vec++; if (got_d[i] !== (a << i) || got_t[i] !== TAG_W'(i) || got_cyc[i] !== got_cyc[0] + i) begin
                    n_err++; $display("FAIL b2b[%0d] got %h/%0d@%0d exp %h/%0d@%0d", i, got_d[i], got_t[i],
                                      got_cyc[i], a << i, i, got_cyc[0] + i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0]      hold_d;
        logic [TAG_W-1:0] hold_t;
        clear_q();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            pend.push_back(mk(2'($urandom_range(0, 2)), 1'b0, {$urandom, $urandom}, 6'($urandom), TAG_W'(10 + i)));
        hold_d = '0; hold_t = '0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0);
            if (i == 1) begin hold_d = out_data; hold_t = out_tag; end
            if (i >= 2) begin
                n_vec++; if (out_data !== hold_d || out_tag !== hold_t) begin
                    n_err++; $display("FAIL bp_stable got %h/%0d exp %h/%0d", out_data, out_tag, hold_d, hold_t);
                end
            end
        end
        n_vec++; if (acc_cyc.size() !== 2) begin n_err++; $display("FAIL bp_accepts got %0d exp 2", acc_cyc.size()); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid got %b exp 1", out_valid); end
        drain(20);
        n_vec++; if (got_d.size() !== 3) begin n_err++; $display("FAIL bp_count got %0d exp 3", got_d.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++; if (got_d[i] !== exp_d[i] || got_t[i] !== TAG_W'(10 + i)) begin
                    n_err++; $display("FAIL bp_data[%0d] got %h/%0d exp %h/%0d", i, got_d[i], got_t[i], exp_d[i], 10 + i);
                end
            end
        end
    endtask

    task automatic test_random();
        int n;
        n = 400;
        clear_q();
        for (int i = 0; i < n; i++)
            pend.push_back(mk(2'($urandom), 1'($urandom), {$urandom, $urandom}, 6'($urandom), TAG_W'($urandom)));
        for (int i = 0; i < 2000 && pend.size() > 0; i++) cycle(1'b1);
        drain(20);
        n_vec++; if (got_d.size() !== n) begin n_err++; $display("FAIL rand_count got %0d exp %0d", got_d.size(), n); end
        else begin
            for (int i = 0; i < n; i++) begin
                n_vec++; if (got_d[i] !== exp_d[i] || got_t[i] !== exp_t[i]) begin
                    n_err++; $display("FAIL rand[%0d] got %h/%0d exp %h/%0d", i, got_d[i], got_t[i], exp_d[i], exp_t[i]);
                end
            end
        end
    endtask

    task automatic test_word();
        logic [63:0] k[3];
        clear_q();
        out_ready = 1'b1;
`ifdef SHIFT_W_OPS_EN
        k[0] = 64'hFFFFFFFFF8000000; k[1] = 64'hFFFFFFFF80000000; k[2] = 64'hFFFFFFFF9ABCDEF0;
        pend.push_back(mk(2'd2, 1'b1, 64'h0000000080000000, 6'd4, 5'd20));
        pend.push_back(mk(2'd0, 1'b1, 64'h0000000000000001, 6'd31, 5'd21));
        pend.push_back(mk(2'd1, 1'b1, 64'h123456789ABCDEF0, 6'd32, 5'd22));
`else
        k[0] = 64'h0000010000000000; k[1] = 64'hFFFFFFFFF8000000; k[2] = 64'h00000000FFFFFFFF;
        pend.push_back(mk(2'd0, 1'b1, 64'h0000000000000001, 6'd40, 5'd20));
        pend.push_back(mk(2'd2, 1'b1, 64'h8000000000000000, 6'd36, 5'd21));
        pend.push_back(mk(2'd1, 1'b1, 64'hFFFFFFFF00000000, 6'd32, 5'd22));
`endif
        drain(20);
        n_vec++; if (got_d.size() !== 3) begin n_err++; $display("FAIL word_count got %0d exp 3", got_d.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++; if (got_d[i] !== k[i] || got_t[i] !== TAG_W'(20 + i)) begin
                    n_err++; $display("FAIL word[%0d] got %h/%0d exp %h/%0d", i, got_d[i], got_t[i], k[i], 20 + i);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        clear_q();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) pend.push_back(mk(2'd0, 1'b0, 64'hFFFF, 6'd1, TAG_W'(i)));
        repeat (3) cycle(1'b0);
        n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL mid_full got %b/%b exp 1/0", out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || out_data !== 64'd0) begin
            n_err++; $display("FAIL mid_async_clear got %b/%h exp 0/0", out_valid, out_data);
        end
        clear_q();
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        pend.push_back(mk(2'd0, 1'b0, 64'h0123456789ABCDEF, 6'd8, 5'd9));
        repeat (6) cycle(1'b0);
        n_vec++; if (got_d.size() !== 1) begin n_err++; $display("FAIL mid_count got %0d exp 1", got_d.size()); end
        else begin
            n_vec++; if (got_d[0] !== 64'h23456789ABCDEF00 || got_t[0] !== 5'd9) begin
                n_err++; $display("FAIL mid_data got %h/%0d exp %h/9", got_d[0], got_t[0], 64'h23456789ABCDEF00);
            end
            n_vec++; if (got_cyc[0] !== acc_cyc[0] + 2) begin
                n_err++; $display("FAIL mid_latency got %0d exp 2", got_cyc[0] - acc_cyc[0]);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; n_vec = 0; n_err = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_word();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_unit_64.md
# shift_unit_64

Pipelined 64-bit shift execution unit for the integer datapath. Accepts SLL/SRL/SRA (and, optionally, RV64 word variants) with a valid/ready handshake, decodes the binary shift amount into the one-hot vector consumed by `ShiftLogic_64`, and realises right and arithmetic shifts around that left-only shifter. It sits between issue and writeback, two register stages deep, with full throughput of one operation per cycle.

## Interface
- `TAG_W`, default 5: width of the destination tag carried alongside each operation.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: an operation is presented.
- `in_ready` out 1: the unit accepts the operation this cycle.
- `in_op` in 2: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
- `in_word` in 1: word (32-bit) variant; honoured only with `SHIFT_W_OPS_EN`.
- `in_a` in 64: operand to shift.
- `in_shamt` in 6: shift amount.
- `in_tag` in TAG_W: destination tag, passed through unmodified.
- `out_valid` out 1: a result is presented.
- `out_ready` in 1: the consumer accepts the result.
- `out_data` out 64: shift result.
- `out_tag` out TAG_W: tag of the result.

## Operation
- Stage 1 (S1) registers the op, word flag, operand, tag, and a one-hot shift vector: bit k is set for k = shamt (word ops: k = shamt[4:0]).
- Stage 2 (S2) computes and registers the result:
  - Operand prep: non-word ops use a. Word SLL/SRL use {32'b0, a[31:0]}. Word SRA uses {{32{a[31]}}, a[31:0]}.
  - SLL: left-shift the prepared operand.
  - SRL/SRA: bit-reverse the operand, left-shift, then bit-reverse the result.
  - SRA fill: compute mask = reverse(all-ones << k). Result |= ~mask & {64{sign}}, where sign is the MSB of the prepared operand.
  - Word ops: the final result is sign-extended from bit 31.
  - Reserved op 11: result 0, tag passed through, handshake unchanged.
- Advance rules:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv.
- Transfers:
  - S1 loads on in_valid & in_ready.
  - S2 loads S1 contents when s1_valid & s2_adv.
  - A valid bit clears when its contents move on and nothing replaces them.
- Registers hold their contents while stalled. `out_data`/`out_tag` are stable while out_valid & !out_ready.
- Shift amount 0 returns the prepared operand (word ops: sign-extended low word). Shift amount 63 is the maximum. There is no wrap-around beyond 6 bits.

## Timing
- Reset values: out_valid 0, out_data 0, out_tag 0, all S1 state 0. `in_ready` is 1 while in reset and immediately after.
- Latency: a result is valid 2 cycles after acceptance when there is no backpressure.
- Throughput: one operation per cycle with out_ready held high.
- `in_ready` is combinational from `out_ready` and the valid bits; there is no combinational path from in_* to out_*.
- Simultaneous accept at the output and input with both stages full: all stages advance in the same cycle, with no bubble.
- Reset mid-operation discards all in-flight operations. out_valid falls asynchronously.

## Configuration
- `SHIFT_W_OPS_EN` defined: word variants (SLLW/SRLW/SRAW) are supported as described above.
- `SHIFT_W_OPS_EN` undefined: `in_word` is ignored, all ops are 64-bit, and the word-prep and sign-extension logic is not synthesised.

## Structure
- Shared package `shift_pkg`:
  - op encodings SHIFT_OP_SLL/SRL/SRA/RSVD;
  - XLEN = 64, SHAMT_W = 6;
  - bit-reverse function.
- Sub-module: `ShiftLogic_64` (datain, one-hot shift, dataout).
  - Instance 1 performs the data shift.
  - Instance 2 shifts all-ones to generate the SRA mask.
- One-hot decode and the handshake logic are local to `shift_unit_64`.

## Test plan
- Reset, then SLL a=0xFAFA0F0FFAFA0F0F, shamt=4, out_ready=1 -> out_valid exactly 2 cycles later, out_data=0xAFA0F0FFAFA0F0F0, tag echoed.
- SRL a=0x8000000000000000, shamt=63 -> 0x0000000000000001. SRA of the same operand with shamt=63 -> 0xFFFFFFFFFFFFFFFF. SRA a=0x7000000000000000, shamt=4 -> 0x0700000000000000.
- Back-to-back stream of 64 ops (SLL, shamt 0..63) with out_ready=1 -> 64 results on consecutive cycles, in order, each matching a << shamt.
- Hold out_ready=0 for 5 cycles with 3 ops offered -> in_ready drops after 2 accepts, out_data/out_tag stay stable, and all 3 results arrive in order once released.
- With `SHIFT_W_OPS_EN`: SRAW a=0x00000000_80000000, shamt=4 -> 0xFFFFFFFFF8000000. SLLW a=0x1, shamt=31 -> 0xFFFFFFFF80000000. SRLW with shamt=32 -> the shift uses shamt[4:0]=0.
- Assert rst_n low with both stages full -> out_valid=0 immediately. After release, the next accepted op completes in 2 cycles with no stale results.
